// File: rtl/core_fetch_unit_pkg.sv
// core_fetch_unit_pkg: shared widths, fetch FSM encoding, queue entry layout
// and the PC alignment helper for the instruction fetch stage.
package core_fetch_unit_pkg;
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int FETCH_ST_WIDTH = 2;

  localparam logic [MEM_ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [FETCH_ST_WIDTH-1:0] {
    FETCH_ST_IDLE = 2'd0,
    FETCH_ST_REQ  = 2'd1,
    FETCH_ST_WAIT = 2'd2
  } fetch_st_e;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] pc;
    logic [MEM_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Word-align a byte address (RV32I without C: low two bits are always 0).
  function automatic logic [MEM_ADDR_WIDTH-1:0] align_pc(input logic [MEM_ADDR_WIDTH-1:0] a);
    return {a[MEM_ADDR_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/core_fetch_unit_queue.sv
// fetch_queue: 2-entry FIFO of {pc, instr} between fetch and decode.
//   clk, rst_n          clock, async active-low reset
//   push, push_pc/instr write one entry (never issued when full)
//   pop                 consume head (ignored when empty)
//   flush               drop all entries; wins over push/pop
//   count               occupancy 0..2
//   head_pc/head_instr  head storage, straight from registers
module fetch_queue
  import core_fetch_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [MEM_ADDR_WIDTH-1:0] push_pc,
  input  logic [MEM_DATA_WIDTH-1:0] push_instr,
  input  logic                      pop,
  input  logic                      flush,
  output logic [1:0]                count,
  output logic [MEM_ADDR_WIDTH-1:0] head_pc,
  output logic [MEM_DATA_WIDTH-1:0] head_instr
);
  fetch_entry_t [1:0] mem_q;
  logic               rd_ptr_q;
  logic               wr_ptr_q;
  logic [1:0]         count_q;
  logic               pop_ok;

  assign pop_ok = pop & (count_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{pc: push_pc, instr: push_instr};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop_ok};
    end
  end

  assign count      = count_q;
  assign head_pc    = mem_q[rd_ptr_q].pc;
  assign head_instr = mem_q[rd_ptr_q].instr;
endmodule

// File: rtl/core_fetch_unit.sv
// core_fetch_unit: RV32I fetch stage. Holds the fetch PC, issues one
// outstanding request at a time on the imem req/gnt/rvalid handshake and
// queues returned words (with their PCs) for decode.
//   imem_*          instruction memory request/response
//   redirect_*      taken branch/jump from execute; flushes and refetches
//   instr_*, pc_o   queue head toward decode (valid/ready)
//   fetch_err_o     one-cycle pulse after a misaligned redirect target
module core_fetch_unit
  import core_fetch_unit_pkg::*;
#(
  parameter logic [MEM_ADDR_WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int                        BUF_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                      imem_gnt_i,
  input  logic                      imem_rvalid_i,
  input  logic [MEM_DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                      redirect_i,
  input  logic [MEM_ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [MEM_DATA_WIDTH-1:0] instr_o,
  output logic [MEM_ADDR_WIDTH-1:0] pc_o,
  output logic                      fetch_err_o
);
  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  fetch_st_e                 state_q;
  logic [MEM_ADDR_WIDTH-1:0] fetch_pc_q, req_pc_q, addr_q, redir_pc;
  logic                      req_q, drop_q, err_q;
  logic                      push, pop;
  logic [1:0]                count, count_after;

  assign redir_pc      = align_pc(redirect_pc_i);
  assign instr_valid_o = (count != 2'd0) & ~redirect_i;
  assign pop           = instr_valid_o & instr_ready_i;
  // A response arriving with a redirect is wrong-path: never queued.
  assign push          = (state_q == FETCH_ST_WAIT) & imem_rvalid_i & ~drop_q & ~redirect_i;
  assign count_after   = count + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= redirect_i & (|redirect_pc_i[1:0]);
      if (redirect_i) fetch_pc_q <= redir_pc;
      unique case (state_q)
        FETCH_ST_IDLE: begin
          if (count < DEPTH) begin
            state_q <= FETCH_ST_REQ;
            req_q   <= 1'b1;
            addr_q  <= redirect_i ? redir_pc : fetch_pc_q;
          end
        end
        FETCH_ST_REQ: begin
          // The pending request keeps its old address until granted; its
          // response is marked for discard instead of being withdrawn.
          if (redirect_i) drop_q <= 1'b1;
          if (imem_gnt_i) begin
            req_pc_q <= addr_q;
            req_q    <= 1'b0;
            state_q  <= FETCH_ST_WAIT;
            // Under drop_q, fetch_pc already holds the redirect target.
            if (!redirect_i && !drop_q) fetch_pc_q <= fetch_pc_q + MEM_ADDR_WIDTH'(4);
          end
        end
        FETCH_ST_WAIT: begin
          if (imem_rvalid_i) begin
            drop_q <= 1'b0;
            if (redirect_i || (count_after < DEPTH)) begin
              state_q <= FETCH_ST_REQ;
              req_q   <= 1'b1;
              addr_q  <= redirect_i ? redir_pc : fetch_pc_q;
            end else begin
              state_q <= FETCH_ST_IDLE;
            end
          end else if (redirect_i) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state_q <= FETCH_ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign fetch_err_o = err_q;

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_pc    (req_pc_q),
    .push_instr (imem_rdata_i),
    .pop        (pop),
    .flush      (redirect_i),
    .count      (count),
    .head_pc    (pc_o),
    .head_instr (instr_o)
  );
endmodule

// File: tb/tb_core_fetch_unit.sv
module tb_core_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        redirect_i, instr_valid_o, instr_ready_i, fetch_err_o;
  logic [31:0] redirect_pc_i, instr_o, pc_o;

  // second instance for the top-of-address-space reset PC
  logic        w_req, w_gnt, w_rvalid, w_redirect, w_valid, w_ready, w_err;
  logic [31:0] w_addr, w_rdata, w_redirect_pc, w_instr, w_pc;

  always #5 clk = ~clk;

  core_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .fetch_err_o(fetch_err_o));

  core_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt),
    .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
    .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc),
    .instr_valid_o(w_valid), .instr_ready_i(w_ready),
    .instr_o(w_instr), .pc_o(w_pc), .fetch_err_o(w_err));

  int n_cmp = 0;
  int n_err = 0;

  // memory model state (one outstanding request)
  bit          mem_rand, mem_const;
  int          fix_lat;
  bit          pend;
  int          pend_wait;
  logic [31:0] pend_addr;
  bit          prev_hold;
  logic [31:0] prev_addr;
  logic [31:0] gnt_log[$];
  logic [31:0] pop_log[$];

  // decode-side reference: the next PC decode must see, and the error pulse
  logic [31:0] exp_pc;
  logic        exp_err;
  int          n_pop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_const ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
  endfunction

  // One clock cycle: memory responds, inputs are driven, decode-side
  // observations are scored against the sequential-PC model.
  task automatic step(input logic redir, input logic [31:0] tgt, input logic rdy);
    if (prev_hold) begin
      n_cmp++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr) begin
        n_err++;
        $display("FAIL req_hold: req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, prev_addr);
      end
    end
    n_cmp++;
    if (imem_req_o && pend) begin
      n_err++;
      $display("FAIL one_outstanding: req=%b while response pending for %h", imem_req_o, pend_addr);
    end
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (pend) begin
      if (pend_wait == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend_addr);
        pend          = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    imem_gnt_i = 1'b0;
    if (imem_req_o && !pend) begin
      imem_gnt_i = mem_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (imem_gnt_i) begin
        pend      = 1'b1;
        pend_addr = imem_addr_o;
        pend_wait = mem_rand ? int'($urandom_range(0, 2)) : fix_lat;
        gnt_log.push_back(imem_addr_o);
      end
    end
    prev_hold     = imem_req_o && !imem_gnt_i;
    prev_addr     = imem_addr_o;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    instr_ready_i = rdy;
    #1;
    n_cmp++;
    if (fetch_err_o !== exp_err) begin
      n_err++;
      $display("FAIL fetch_err: got %b expected %b", fetch_err_o, exp_err);
    end
    if (redir) begin
      n_cmp++;
      if (instr_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL valid_on_redirect: got %b expected 0", instr_valid_o);
      end
    end
    if (instr_valid_o && instr_ready_i) begin
      n_cmp++;
      if (pc_o !== exp_pc) begin
        n_err++;
        $display("FAIL pop_pc: got %h expected %h", pc_o, exp_pc);
      end
      n_cmp++;
      if (instr_o !== mem_word(exp_pc)) begin
        n_err++;
        $display("FAIL pop_instr: got %h expected %h", instr_o, mem_word(exp_pc));
      end
      pop_log.push_back(pc_o);
      n_pop++;
      exp_pc = exp_pc + 32'd4;
    end
    exp_err = redir && (tgt[1:0] != 2'b00);
    if (redir) exp_pc = {tgt[31:2], 2'b00};
    @(posedge clk);
    #1;
    redirect_i    = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_i = 0; redirect_pc_i = 0; instr_ready_i = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    w_gnt = 0; w_rvalid = 0; w_rdata = 0; w_redirect = 0; w_redirect_pc = 0; w_ready = 0;
    pend = 0; pend_wait = 0; prev_hold = 0; fix_lat = 0; mem_rand = 0;
    exp_pc = 32'h0; exp_err = 1'b0; n_pop = 0;
    gnt_log.delete();
    pop_log.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output logic [31:0] a, output bit ok);
    int g = 0;
    while (!imem_req_o && g < 30) begin
      step(1'b0, 32'h0, 1'b1);
      g++;
    end
    ok = imem_req_o;
    a  = imem_addr_o;
  endtask

  task automatic wait_pop(output logic [31:0] p, output bit ok);
    int g = 0;
    int n0 = n_pop;
    while (n_pop == n0 && g < 30) begin
      step(1'b0, 32'h0, 1'b1);
      g++;
    end
    ok = (n_pop != n0);
    p  = ok ? pop_log[pop_log.size()-1] : 32'hx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_o, instr_valid_o, fetch_err_o} !== 3'b000 || imem_addr_o !== 32'h0 ||
        instr_o !== 32'h0 || pc_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_values: req=%b valid=%b err=%b addr=%h instr=%h pc=%h expected all 0",
               imem_req_o, instr_valid_o, fetch_err_o, imem_addr_o, instr_o, pc_o);
    end
    do_reset();
    n_cmp++;
    if (imem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL req_after_release: got %b expected 0", imem_req_o);
    end
  endtask

  task automatic test_sequential();
    int steps;
    mem_const = 1;
    do_reset();
    step(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      n_err++;
      $display("FAIL first_req: req=%b addr=%h expected req=1 addr=00000000", imem_req_o, imem_addr_o);
    end
    steps = 1;
    while (!instr_valid_o && steps < 10) begin
      step(1'b0, 32'h0, 1'b1);
      steps++;
    end
    n_cmp++;
    if (steps != 3) begin
      n_err++;
      $display("FAIL first_valid_latency: got %0d cycles expected 3", steps);
    end
    repeat (6) step(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (gnt_log.size() < 3 || gnt_log[0] !== 32'h0 || gnt_log[1] !== 32'h4 || gnt_log[2] !== 32'h8) begin
      n_err++;
      $display("FAIL fetch_order: got %0d grants (first %h) expected 0,4,8", gnt_log.size(),
               gnt_log.size() > 0 ? gnt_log[0] : 32'hx);
    end
    n_cmp++;
    if (pop_log.size() != 3) begin
      n_err++;
      $display("FAIL seq_throughput: got %0d pops expected 3", pop_log.size());
    end
    mem_const = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (10) step(1'b0, 32'h0, 1'b0);
    n_cmp++;
    if (gnt_log.size() != 2 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_park: grants=%0d req=%b valid=%b expected 2,0,1",
               gnt_log.size(), imem_req_o, instr_valid_o);
    end
    repeat (2) step(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (pop_log.size() != 2 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4) begin
      n_err++;
      $display("FAIL backpressure_drain: got %0d pops (first %h) expected 0,4", pop_log.size(),
               pop_log.size() > 0 ? pop_log[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_wait();
    int g = 0;
    logic [31:0] a;
    bit ok;
    do_reset();
    fix_lat = 3;
    while (!(pend && pend_addr == 32'h8 && pend_wait == 3) && g < 60) begin
      step(1'b0, 32'h0, 1'b1);
      g++;
    end
    step(1'b1, 32'h100, 1'b1);
    fix_lat = 0;
    wait_req(a, ok);
    n_cmp++;
    if (!ok || a !== 32'h100) begin
      n_err++;
      $display("FAIL redir_wait_addr: got %h (req=%b) expected 00000100", a, ok);
    end
    wait_pop(a, ok);
    n_cmp++;
    if (!ok || a !== 32'h100) begin
      n_err++;
      $display("FAIL redir_wait_pc: got %h expected 00000100", a);
    end
  endtask

  task automatic test_redirect_gnt(input bit on_rvalid);
    int g = 0;
    logic [31:0] a;
    bit ok;
    do_reset();
    if (on_rvalid)
      while (!(pend && pend_wait == 0 && pend_addr == 32'hC) && g < 60) begin step(1'b0, 32'h0, 1'b1); g++; end
    else
      while (!(imem_req_o && imem_addr_o == 32'hC) && g < 60) begin step(1'b0, 32'h0, 1'b1); g++; end
    step(1'b1, 32'h200, 1'b1);
    wait_req(a, ok);
    n_cmp++;
    if (!ok || a !== 32'h200) begin
      n_err++;
      $display("FAIL redir_%s_addr: got %h expected 00000200", on_rvalid ? "rvalid" : "gnt", a);
    end
    wait_pop(a, ok);
    n_cmp++;
    if (!ok || a !== 32'h200) begin
      n_err++;
      $display("FAIL redir_%s_pc: got %h expected 00000200", on_rvalid ? "rvalid" : "gnt", a);
    end
  endtask

  task automatic test_misaligned();
    int g = 0;
    int pulses = 0;
    int g0;
    do_reset();
    while (!(pend && pend_wait == 0) && g < 20) begin step(1'b0, 32'h0, 1'b1); g++; end
    step(1'b1, 32'h302, 1'b1);
    g0 = gnt_log.size();
    repeat (8) begin
      if (fetch_err_o === 1'b1) pulses++;
      step(1'b0, 32'h0, 1'b1);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL err_pulse_len: got %0d cycles expected 1", pulses);
    end
    n_cmp++;
    if (gnt_log.size() <= g0 || gnt_log[g0] !== 32'h300) begin
      n_err++;
      $display("FAIL misaligned_refetch: got %h expected 00000300", gnt_log.size() > g0 ? gnt_log[g0] : 32'hx);
    end
  endtask

  task automatic test_random();
    int n0;
    logic [31:0] tgt;
    do_reset();
    mem_rand = 1;
    n0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      tgt = {$urandom_range(0, 1023), 2'b00};
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 19) == 0, tgt, $urandom_range(0, 2) != 0);
    end
    n_cmp++;
    if (n_pop - n0 < 100) begin
      n_err++;
      $display("FAIL random_progress: got %0d pops expected at least 100", n_pop - n0);
    end
    mem_rand = 0;
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] ga[$];
    bit wpend = 0;
    int g = 0;
    do_reset();
    w_ready = 0;
    while (ga.size() < 2 && g < 20) begin
      w_rvalid = wpend;
      w_rdata  = 32'h0000_0013;
      wpend    = 0;
      w_gnt    = w_req;
      if (w_req) begin ga.push_back(w_addr); wpend = 1; end
      @(posedge clk);
      #1;
      g++;
    end
    w_gnt = 0; w_rvalid = 0;
    n_cmp++;
    if (ga.size() != 2 || ga[0] !== 32'hFFFF_FFFC || ga[1] !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_addr: got %0d grants (last %h) expected FFFFFFFC then 00000000",
               ga.size(), ga.size() > 0 ? ga[ga.size()-1] : 32'hx);
    end
    n_cmp++;
    if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_req !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_head: valid=%b pc=%h req=%b expected 1 FFFFFFFC 0", w_valid, w_pc, w_req);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (w_req !== 1'b0 || w_valid !== 1'b0 || w_addr !== 32'hFFFF_FFFC || w_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_in_wait: req=%b valid=%b addr=%h pc=%h expected 0 0 FFFFFFFC 0",
               w_req, w_valid, w_addr, w_pc);
    end
    do_reset();
  endtask

  initial begin
    mem_const = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt(1'b0);
    test_redirect_gnt(1'b1);
    test_misaligned();
    test_random();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
